// File: rtl/led_mode_ctrl.sv
// ---------------------------------------------------------------------------
// led_mode_ctrl
// Pattern sequencer for an 8-LED bank. A prescaler derives a step tick from
// sys_clk; on each tick the current display mode advances its pattern. Modes
// are OFF, BLINK, RUN (rotating light) and BOUNCE (light sweeping back and
// forth). Modes advance on a debounced key pulse or automatically after
// AUTO_STEPS ticks.
//
// Ports:
//   sys_clk    in   1  system clock
//   sys_rst    in   1  synchronous reset, active-high
//   en         in   1  run enable; 0 freezes stepping (prescaler, pattern, auto count)
//   mode_next  in   1  single-cycle pulse, advance to next mode (wraps 3->0)
//   auto_cycle in   1  level, enables automatic advance (1->2->3->1, OFF skipped)
//   led_out    out  8  LED drive, 1 = on, registered
//   mode       out  2  0 OFF, 1 BLINK, 2 RUN, 3 BOUNCE, registered
//   step_tick  out  1  en && prescaler == TICK_CYC-1 (decoded from registers)
// ---------------------------------------------------------------------------
module led_mode_ctrl #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int TICK_HZ    = 4,
    parameter int AUTO_STEPS = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       en,
    input  logic       mode_next,
    input  logic       auto_cycle,
    output logic [7:0] led_out,
    output logic [1:0] mode,
    output logic       step_tick
);

    localparam int TICK_CYC = CLK_FREQ / TICK_HZ;
    localparam int PW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int AW       = (AUTO_STEPS > 1) ? $clog2(AUTO_STEPS) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_CYC - 1);
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_STEPS - 1);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_RUN    = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_e;

    // Bounce direction encoding: 0 = moving towards bit 7, 1 = towards bit 0.
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    mode_e         r_mode;
    logic [7:0]    r_led;
    logic [PW-1:0] r_pre;
    logic [AW-1:0] r_cnt;
    logic          r_dir;

    mode_e         w_mode_nxt;
    logic [7:0]    w_led_nxt;
    logic [PW-1:0] w_pre_nxt;
    logic [AW-1:0] w_cnt_nxt;
    logic          w_dir_nxt;
    logic          w_change;
    logic          w_tick;
    logic          w_auto_adv;

    assign w_tick     = en && (r_pre == PRE_LAST);
    assign w_auto_adv = auto_cycle && en && (r_mode != MODE_OFF) && w_tick
                        && (r_cnt == AUTO_LAST);

    assign step_tick = w_tick;
    assign led_out   = r_led;
    assign mode      = r_mode;

    // Next-state: mode change (manual beats auto) loads entry values and
    // discards any coincident step; otherwise prescaler/pattern/auto count run.
    always_comb begin
        w_mode_nxt = r_mode;
        w_led_nxt  = r_led;
        w_pre_nxt  = r_pre;
        w_cnt_nxt  = r_cnt;
        w_dir_nxt  = r_dir;
        w_change   = 1'b0;

        if (mode_next) begin
            w_change   = 1'b1;
            w_mode_nxt = mode_e'(r_mode + 2'd1);
        end else if (w_auto_adv) begin
            w_change   = 1'b1;
            w_mode_nxt = (r_mode == MODE_BOUNCE) ? MODE_BLINK : mode_e'(r_mode + 2'd1);
        end else begin
            w_change   = 1'b0;
        end

        if (w_change) begin
            w_pre_nxt = '0;
            w_cnt_nxt = '0;
            w_dir_nxt = DIR_LEFT;
            case (w_mode_nxt)
                MODE_OFF:    w_led_nxt = 8'h00;
                MODE_BLINK:  w_led_nxt = 8'hFF;
                MODE_RUN:    w_led_nxt = 8'h01;
                MODE_BOUNCE: w_led_nxt = 8'h01;
                default:     w_led_nxt = 8'h00;
            endcase
        end else begin
            if (en) begin
                w_pre_nxt = w_tick ? '0 : (r_pre + PW'(1));
            end else begin
                w_pre_nxt = r_pre;
            end

            // The count never reaches past AUTO_LAST here: that tick advances the mode.
            if (!auto_cycle || (r_mode == MODE_OFF)) begin
                w_cnt_nxt = '0;
            end else if (w_tick) begin
                w_cnt_nxt = r_cnt + AW'(1);
            end else begin
                w_cnt_nxt = r_cnt;
            end

            if (w_tick) begin
                case (r_mode)
                    MODE_OFF:   w_led_nxt = 8'h00;
                    MODE_BLINK: w_led_nxt = ~r_led;
                    MODE_RUN:   w_led_nxt = {r_led[6:0], r_led[7]};
                    MODE_BOUNCE: begin
                        // Reverse at the ends so 80 and 01 each appear once per sweep.
                        if (r_dir == DIR_LEFT) begin
                            if (r_led[7]) begin
                                w_led_nxt = r_led >> 1;
                                w_dir_nxt = DIR_RIGHT;
                            end else begin
                                w_led_nxt = r_led << 1;
                                w_dir_nxt = DIR_LEFT;
                            end
                        end else begin
                            if (r_led[0]) begin
                                w_led_nxt = r_led << 1;
                                w_dir_nxt = DIR_LEFT;
                            end else begin
                                w_led_nxt = r_led >> 1;
                                w_dir_nxt = DIR_RIGHT;
                            end
                        end
                    end
                    default:    w_led_nxt = 8'h00;
                endcase
            end else begin
                w_led_nxt = r_led;
            end
        end
    end

    // State register with synchronous reset taking priority over all inputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_mode <= MODE_OFF;
            r_led  <= 8'h00;
            r_pre  <= '0;
            r_cnt  <= '0;
            r_dir  <= DIR_LEFT;
        end else begin
            r_mode <= w_mode_nxt;
            r_led  <= w_led_nxt;
            r_pre  <= w_pre_nxt;
            r_cnt  <= w_cnt_nxt;
            r_dir  <= w_dir_nxt;
        end
    end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_mode_ctrl
// Scoreboard bench: each stimulus cycle pushes the expected visible state
// (mode, led_out, step_tick) computed by a position-index reference model;
// a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_led_mode_ctrl;

    localparam int TC = 4;
    localparam int AS = 3;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       en;
    logic       mode_next;
    logic       auto_cycle;
    logic [7:0] led_out;
    logic [1:0] mode;
    logic       step_tick;

    always #5 sys_clk = ~sys_clk;

    led_mode_ctrl #(
        .CLK_FREQ  (8),
        .TICK_HZ   (2),
        .AUTO_STEPS(AS)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .en        (en),
        .mode_next (mode_next),
        .auto_cycle(auto_cycle),
        .led_out   (led_out),
        .mode      (mode),
        .step_tick (step_tick)
    );

    typedef struct packed {
        logic [1:0] md;
        logic [7:0] led;
        logic       tick;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: mode, pattern position index, prescaler, auto count.
    int m_mode  = 0;
    int m_pos   = 0;
    int m_pre   = 0;
    int m_cnt   = 0;
    bit m_known = 1'b0;
    bit ac_r    = 1'b0;

    function automatic logic [7:0] led_of(input int md, input int pos);
        logic [7:0] v;
        case (md)
            0:       v = 8'h00;
            1:       v = (pos % 2 == 0) ? 8'hFF : 8'h00;
            2:       v = 8'(1 << (pos % 8));
            default: v = (pos <= 7) ? 8'(1 << pos) : 8'(1 << (14 - pos));
        endcase
        return v;
    endfunction

    function automatic int period_of(input int md);
        case (md)
            1:       return 2;
            2:       return 8;
            3:       return 14;
            default: return 1;
        endcase
    endfunction

    // One clock cycle: apply inputs, record expected visible state, advance model.
    task automatic cyc(input bit r, input bit e, input bit mn, input bit ac);
        bit   tick;
        bit   adv;
        exp_t x;
        @(posedge sys_clk);
        #1;
        sys_rst    = r;
        en         = e;
        mode_next  = mn;
        auto_cycle = ac;
        tick = e && (m_pre == TC - 1);
        if (m_known) begin
            x.md   = 2'(m_mode);
            x.led  = led_of(m_mode, m_pos);
            x.tick = tick;
            q.push_back(x);
        end
        if (r) begin
            m_mode = 0; m_pos = 0; m_pre = 0; m_cnt = 0; m_known = 1'b1;
        end else begin
            adv = ac && e && (m_mode != 0) && tick && (m_cnt == AS - 1);
            if (mn) begin
                m_mode = (m_mode + 1) % 4;
                m_pos = 0; m_pre = 0; m_cnt = 0;
            end else if (adv) begin
                m_mode = (m_mode == 3) ? 1 : m_mode + 1;
                m_pos = 0; m_pre = 0; m_cnt = 0;
            end else begin
                if (e) m_pre = (m_pre + 1) % TC;
                if (tick) m_pos = (m_pos + 1) % period_of(m_mode);
                if (!ac || m_mode == 0) m_cnt = 0;
                else if (tick) m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic idle(input int n, input bit ac);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, ac);
    endtask

    task automatic goto_mode(input int target, input bit ac);
        for (int i = 0; i < 4 && m_mode != target; i++) cyc(1'b0, 1'b1, 1'b1, ac);
        checks++;
        if (m_mode != target) begin
            errors++;
            $display("FAIL goto_mode: reached mode %0d, required %0d", m_mode, target);
        end
    endtask

    task automatic bound_fail(input string name);
        errors++;
        $display("FAIL %s: wait bound expired, condition not reached", name);
    endtask

    // Monitor: compare DUT outputs against the oldest expectation.
    always @(negedge sys_clk) begin
        exp_t x;
        if (q.size() > 0) begin
            x = q.pop_front();
            checks++;
            if (mode !== x.md || led_out !== x.led || step_tick !== x.tick) begin
                errors++;
                $display("FAIL outputs @%0t: got mode=%0d led=%02h tick=%0b, required mode=%0d led=%02h tick=%0b",
                         $time, mode, led_out, step_tick, x.md, x.led, x.tick);
            end
        end
    end

    initial begin
        sys_rst = 1'b1; en = 1'b1; mode_next = 1'b0; auto_cycle = 1'b0;

        // Reset then idle in OFF
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(12, 1'b0);

        // Manual walk: BLINK, RUN, BOUNCE
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        idle(12, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        idle(36, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        idle(70, 1'b0);

        // Auto cycle from BLINK through RUN, BOUNCE, back to BLINK
        goto_mode(1, 1'b0);
        idle(60, 1'b1);
        // Auto cycle held in OFF
        goto_mode(0, 1'b1);
        idle(40, 1'b1);

        // Collision: mode_next on the step tick while RUN shows 04
        goto_mode(2, 1'b0);
        for (int k = 0; k < 64 && !(m_pos == 2 && m_pre == TC - 1); k++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (!(m_pos == 2 && m_pre == TC - 1)) bound_fail("run_at_04");
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        idle(6, 1'b0);

        // Collision: mode_next on the auto-advance tick
        goto_mode(1, 1'b1);
        for (int k = 0; k < 64 && !(m_cnt == AS - 1 && m_pre == TC - 1); k++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (!(m_cnt == AS - 1 && m_pre == TC - 1)) bound_fail("auto_tick");
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        idle(6, 1'b1);

        // Freeze at BLINK FF with prescaler 2
        goto_mode(1, 1'b0);
        for (int k = 0; k < 64 && !(m_pre == 2 && m_pos % 2 == 0); k++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (!(m_pre == 2 && m_pos % 2 == 0)) bound_fail("blink_pre2");
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        idle(8, 1'b0);

        // Reset mid-BOUNCE
        goto_mode(3, 1'b0);
        idle(10, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        idle(6, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) ac_r = ~ac_r;
            cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 24) == 0), ac_r);
        end

        @(negedge sys_clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
